// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and DDRAM address helpers for the LCD bus decoder.
package lcd_pkg;

  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_HOME      = 8'h02;
  localparam logic [7:0] LCD_ENTRY_PFX = 8'h04;
  localparam logic [7:0] LCD_DISP_PFX  = 8'h08;
  localparam logic [7:0] LCD_SHIFT_PFX = 8'h10;
  localparam logic [7:0] LCD_FUNC_PFX  = 8'h20;
  localparam logic [7:0] LCD_CGRAM_PFX = 8'h40;
  localparam logic [7:0] LCD_DDRAM_PFX = 8'h80;

  localparam logic [6:0] LINE0_BASE = 7'h00;
  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam int unsigned LINE_LEN  = 40;
  localparam int unsigned VIS_COLS  = 16;
  localparam logic [7:0] LCD_SPACE  = 8'h20;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } lcd_state_e;

  function automatic logic lcd_addr_legal(input logic [6:0] a);
    return (a <= 7'(LINE0_BASE + 7'(LINE_LEN - 1))) ||
           ((a >= LINE1_BASE) && (a <= 7'(LINE1_BASE + 7'(LINE_LEN - 1))));
  endfunction

  // Walks the two 40-cell lines as one 80-cell ring in DDRAM address space.
  function automatic logic [6:0] lcd_step(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      case (a)
        7'h27:   r = LINE1_BASE;
        7'h67:   r = LINE0_BASE;
        default: r = a + 7'd1;
      endcase
    end else begin
      case (a)
        7'h00:   r = 7'h67;
        7'h40:   r = 7'h27;
        default: r = a - 7'd1;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/lcd_sync.sv
// Multi-flop synchronizer for a bundle of asynchronous inputs.
module lcd_sync #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign q_o = r_stage[DEPTH-1];

endmodule

// File: rtl/lcd_bus_decoder.sv
// Passive HD44780 write-bus receiver: decodes instructions/data and keeps a
// shadow of the visible 2x16 display behind a registered read port.
module lcd_bus_decoder
  import lcd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned CLEAR_CYCLES = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       lcd_e_i,
  input  logic       lcd_rs_i,
  input  logic [7:0] lcd_data_i,
  input  logic [4:0] rd_addr_i,
  output logic [7:0] rd_data_o,
  output logic       cmd_valid_o,
  output logic [7:0] cmd_o,
  output logic       char_valid_o,
  output logic [6:0] cursor_o,
  output logic       disp_on_o,
  output logic       busy_o,
  output logic       err_o
);

  logic [9:0] w_sync;
  logic       w_e;
  logic       w_rs;
  logic [7:0] w_d;
  logic       w_wr_ev;
  logic [6:0] w_col;
  logic       w_visible;
  logic [4:0] w_wr_idx;
  logic [6:0] w_next_cur;

  lcd_state_e r_state;
  logic       r_e_prev;
  logic [6:0] r_cursor;
  logic       r_inc;
  logic       r_disp;
  logic       r_busy;
  logic [7:0] r_cmd;
  logic       r_cmd_valid;
  logic       r_char_valid;
  logic       r_err;
  logic [4:0] r_clr_idx;
  logic [7:0] r_rd;
  logic [7:0] r_buf [32];

  lcd_sync #(
    .WIDTH (10),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    ({lcd_e_i, lcd_rs_i, lcd_data_i}),
    .q_o    (w_sync)
  );

  assign w_e     = w_sync[9];
  assign w_rs    = w_sync[8];
  assign w_d     = w_sync[7:0];
  assign w_wr_ev = r_e_prev & ~w_e;

  always_comb begin
    w_col      = r_cursor[6] ? (r_cursor - LINE1_BASE) : (r_cursor - LINE0_BASE);
    w_visible  = (w_col < 7'(VIS_COLS));
    w_wr_idx   = {r_cursor[6], w_col[3:0]};
    w_next_cur = lcd_step(r_cursor, r_inc);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_e_prev     <= 1'b0;
      r_cursor     <= '0;
      r_inc        <= 1'b1;
      r_disp       <= 1'b0;
      r_busy       <= 1'b0;
      r_cmd        <= '0;
      r_cmd_valid  <= 1'b0;
      r_char_valid <= 1'b0;
      r_err        <= 1'b0;
      r_clr_idx    <= '0;
      r_rd         <= LCD_SPACE;
      for (int unsigned i = 0; i < 32; i++) r_buf[i] <= LCD_SPACE;
    end else begin
      r_e_prev     <= w_e;
      r_cmd_valid  <= 1'b0;
      r_char_valid <= 1'b0;
      r_err        <= 1'b0;
      // Read samples the pre-update array, so a same-cycle write returns old data.
      r_rd         <= r_buf[rd_addr_i];

      case (r_state)
        ST_IDLE: begin
          if (w_wr_ev) begin
            if (w_rs) begin
              if (w_visible) r_buf[w_wr_idx] <= w_d;
              r_cursor     <= w_next_cur;
              r_char_valid <= 1'b1;
            end else begin
              casez (w_d)
                8'b1???????: begin
                  if (lcd_addr_legal(w_d[6:0])) begin
                    r_cursor    <= w_d[6:0];
                    r_cmd       <= w_d;
                    r_cmd_valid <= 1'b1;
                  end else begin
                    r_err <= 1'b1;
                  end
                end
                8'b01??????: r_err <= 1'b1;
                8'b001?????, 8'b0001????: begin
                  r_cmd       <= w_d;
                  r_cmd_valid <= 1'b1;
                end
                8'b00001???: begin
                  r_disp      <= w_d[2];
                  r_cmd       <= w_d;
                  r_cmd_valid <= 1'b1;
                end
                8'b000001??: begin
                  r_inc       <= w_d[1];
                  r_cmd       <= w_d;
                  r_cmd_valid <= 1'b1;
                end
                8'b0000001?: begin
                  r_cursor    <= LINE0_BASE;
                  r_cmd       <= w_d;
                  r_cmd_valid <= 1'b1;
                end
                8'b00000001: begin
                  r_cursor    <= LINE0_BASE;
                  r_inc       <= 1'b1;
                  r_cmd       <= w_d;
                  r_cmd_valid <= 1'b1;
                  r_busy      <= 1'b1;
                  r_clr_idx   <= '0;
                  r_state     <= ST_CLEAR;
                end
                default: r_err <= 1'b1;
              endcase
            end
          end
        end

        ST_CLEAR: begin
          r_buf[r_clr_idx] <= LCD_SPACE;
          if (w_wr_ev) r_err <= 1'b1;
          if (r_clr_idx == 5'(CLEAR_CYCLES - 1)) begin
            r_clr_idx <= '0;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_clr_idx <= r_clr_idx + 5'd1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_data_o    = r_rd;
  assign cmd_valid_o  = r_cmd_valid;
  assign cmd_o        = r_cmd;
  assign char_valid_o = r_char_valid;
  assign cursor_o     = r_cursor;
  assign disp_on_o    = r_disp;
  assign busy_o       = r_busy;
  assign err_o        = r_err;

endmodule
